// File: rtl/bcd_digit_source_if.sv
// Handshake bundle between the BCD digit source and its downstream consumer.
// Latency: none (wires only).
// Backpressure: carried on ready; valid holds a digit until ready accepts it.
//
// Signals: en/up_dn/load/d/ready come from the producer/consumer side;
// b3..b0/valid/tc/err are driven by the digit source. With
// BCD_DIGIT_SOURCE_GRAY_EN defined, g3..g0 carry the Gray code of the digit.
interface bcd_digit_source_if;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] d;
    logic       ready;
    logic       b3;
    logic       b2;
    logic       b1;
    logic       b0;
    logic       valid;
    logic       tc;
    logic       err;
`ifdef BCD_DIGIT_SOURCE_GRAY_EN
    logic       g3;
    logic       g2;
    logic       g1;
    logic       g0;
`endif

    // master: the digit source itself
    modport master (
        input  en, up_dn, load, d, ready,
`ifdef BCD_DIGIT_SOURCE_GRAY_EN
        output g3, g2, g1, g0,
`endif
        output b3, b2, b1, b0, valid, tc, err
    );

    // slave: the controller/consumer around it
    modport slave (
        output en, up_dn, load, d, ready,
`ifdef BCD_DIGIT_SOURCE_GRAY_EN
        input  g3, g2, g1, g0,
`endif
        input  b3, b2, b1, b0, valid, tc, err
    );
endinterface

// File: rtl/bcd_digit_source.sv
// Single-digit BCD up/down counter with parallel load, feeding a valid/ready stream.
// Latency: accepted load/advance appears on b3..b0 with valid=1 one cycle later.
// Backpressure: digit held while valid=1 and ready=0; load/en stall until the slot frees.
//
// Ports: clk (rising edge), rst_n (synchronous, active-low), bus (master modport):
//   inputs en, up_dn, load, d[3:0], ready; outputs b3..b0, valid, tc, err.
// Optional macro BCD_DIGIT_SOURCE_GRAY_EN adds registered Gray outputs g3..g0.
module bcd_digit_source (
    input  logic                clk,
    input  logic                rst_n,
    bcd_digit_source_if.master  bus
);
    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_nxt_state;
    logic [3:0] r_cnt;
    logic [3:0] w_nxt_cnt;
    logic       r_tc;
    logic       w_nxt_tc;
    logic       r_err;
    logic       w_nxt_err;
    logic       w_xfer;
    logic       w_slot_free;
    logic [3:0] w_cnt_up;
    logic [3:0] w_cnt_dn;

    // A transfer retires the held digit; the slot is free if empty or retiring now.
    assign w_xfer      = (r_state == S_HOLD) && bus.ready;
    assign w_slot_free = (r_state == S_EMPTY) || bus.ready;

    // Decade wrap arithmetic; cnt never leaves 0..9 so these cover every case.
    assign w_cnt_up = (r_cnt == 4'd9) ? 4'd0 : r_cnt + 4'd1;
    assign w_cnt_dn = (r_cnt == 4'd0) ? 4'd9 : r_cnt - 4'd1;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_nxt_tc    = 1'b0;
        w_nxt_err   = 1'b0;
        if (bus.load) begin
            // A load that cannot be taken is dropped silently; the producer holds it.
            if (w_slot_free) begin
                if (bus.d <= 4'd9) begin
                    w_nxt_cnt   = bus.d;
                    w_nxt_state = S_HOLD;
                end else begin
                    w_nxt_err = 1'b1;
                    if (w_xfer) begin
                        w_nxt_state = S_EMPTY;
                    end
                end
            end
        end else if (bus.en) begin
            if (w_slot_free) begin
                w_nxt_state = S_HOLD;
                if (bus.up_dn) begin
                    w_nxt_cnt = w_cnt_up;
                    w_nxt_tc  = (r_cnt == 4'd9);
                end else begin
                    w_nxt_cnt = w_cnt_dn;
                    w_nxt_tc  = (r_cnt == 4'd0);
                end
            end
        end else if (w_xfer) begin
            w_nxt_state = S_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_EMPTY;
            r_cnt   <= 4'd0;
            r_tc    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
            r_tc    <= w_nxt_tc;
            r_err   <= w_nxt_err;
        end
    end

    assign bus.b3    = r_cnt[3];
    assign bus.b2    = r_cnt[2];
    assign bus.b1    = r_cnt[1];
    assign bus.b0    = r_cnt[0];
    assign bus.valid = (r_state == S_HOLD);
    assign bus.tc    = r_tc;
    assign bus.err   = r_err;

`ifdef BCD_DIGIT_SOURCE_GRAY_EN
    // Registered from the next count so Gray and BCD change on the same edge.
    logic [3:0] r_gray;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_gray <= 4'd0;
        end else begin
            r_gray <= w_nxt_cnt ^ (w_nxt_cnt >> 1);
        end
    end

    assign bus.g3 = r_gray[3];
    assign bus.g2 = r_gray[2];
    assign bus.g1 = r_gray[1];
    assign bus.g0 = r_gray[0];
`endif
endmodule
